// File: rtl/shared_counter_pkg.sv
// Shared types and widths for the shared 9-bit counter write master.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package shared_counter_pkg;

  // Register data width.
  localparam int CNT_W  = 9;

  // Strobe hold counter width (HOLD range 1..15).
  localparam int HOLD_W = 4;

  // Readback timeout counter width (TIMEOUT range 1..255).
  localparam int TMO_W  = 8;

  // State encodings kept as plain constants so older code can still refer to them.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_STROBE  = 3'd1;
  localparam logic [2:0] ST_RELEASE = 3'd2;
  localparam logic [2:0] ST_VERIFY  = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    STROBE  = ST_STROBE,
    RELEASE = ST_RELEASE,
    VERIFY  = ST_VERIFY,
    DONE    = ST_DONE
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a last-served register.
// Latency: combinational grant; last-served updates on the granting edge.
// Backpressure: grants only while en is high; requesters hold req until served.
module rr_arbiter2 (
  input  logic clk,
  input  logic nrst,
  input  logic req_a,
  input  logic req_b,
  input  logic en,
  output logic gnt_a,
  output logic gnt_b
);

  // High when B was the most recently granted client; reset makes A preferred.
  logic last_b;

  // A lone requester wins; on contention the client not served last wins.
  always_comb begin
    gnt_a = en & req_a & (~req_b | last_b);
    gnt_b = en & req_b & (~req_a | ~last_b);
  end

  // Remember who was served so contention alternates between clients.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      last_b <= 1'b1;
    end else if (gnt_a) begin
      last_b <= 1'b0;
    end else if (gnt_b) begin
      last_b <= 1'b1;
    end
  end

endmodule

// File: rtl/shared_counter_writer.sv
// Write master for the shared counter register: arbitrates A/B, strobes, verifies readback.
// Latency: ack HOLD+3 cycles after the request is sampled on a match, HOLD+2+TIMEOUT on timeout.
// Backpressure: req is a level held until ack; one write in flight, other client waits in req.
module shared_counter_writer
  import shared_counter_pkg::*;
#(
  parameter int HOLD    = 2,   // strobe high cycles, 1..15
  parameter int TIMEOUT = 15   // readback compare cycles before error, 1..255
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             a_req,
  input  logic [CNT_W-1:0] a_data,
  output logic             a_ack,
  output logic             a_err,
  input  logic             b_req,
  input  logic [CNT_W-1:0] b_data,
  output logic             b_ack,
  output logic             b_err,
  output logic [CNT_W-1:0] wrdata1,
  output logic             wr1,
  output logic [CNT_W-1:0] wrdata2,
  output logic             wr2,
  input  logic [CNT_W-1:0] value,
  output logic             busy
);

  // Counters are loaded with N-1 and run down to zero, giving exactly N cycles.
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_DEC  = HOLD_W'(1);
  localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0]  TMO_DEC   = TMO_W'(1);

  state_t             state;
  state_t             state_n;
  logic               arb_en;
  logic               gnt_a;
  logic               gnt_b;
  logic               sel_b;      // granted client of the write in flight
  logic [CNT_W-1:0]   data_q;     // data being written, used for readback compare
  logic [HOLD_W-1:0]  hold_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               hold_done;
  logic               tmo_done;
  logic               match;

  assign arb_en    = (state == IDLE);
  assign hold_done = (hold_cnt == '0);
  assign tmo_done  = (tmo_cnt == '0);
  assign match     = (value == data_q);

  rr_arbiter2 u_arb (
    .clk   (clk),
    .nrst  (nrst),
    .req_a (a_req),
    .req_b (b_req),
    .en    (arb_en),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  // Next-state decode for the write sequence.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (gnt_a || gnt_b)   state_n = STROBE;
      STROBE:  if (hold_done)        state_n = RELEASE;
      RELEASE:                       state_n = VERIFY;
      VERIFY:  if (match || tmo_done) state_n = DONE;
      DONE:                          state_n = IDLE;
      default:                       state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Grant latch, hold countdown and readback timeout countdown.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sel_b    <= 1'b0;
      data_q   <= '0;
      hold_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_a || gnt_b) begin
            sel_b    <= gnt_b;
            data_q   <= gnt_b ? b_data : a_data;
            hold_cnt <= HOLD_LOAD;
          end
        end
        STROBE: begin
          if (!hold_done) begin
            hold_cnt <= hold_cnt - HOLD_DEC;
          end
        end
        RELEASE: begin
          tmo_cnt <= TMO_LOAD;
        end
        VERIFY: begin
          if (!tmo_done) begin
            tmo_cnt <= tmo_cnt - TMO_DEC;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Strobe drivers: only the granted port ever rises, and it drops when the hold expires.
  // wrdataX is only reloaded on grant so it holds its last value when idle.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr1     <= 1'b0;
      wr2     <= 1'b0;
      wrdata1 <= '0;
      wrdata2 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_a) begin
            wr1     <= 1'b1;
            wrdata1 <= a_data;
          end else if (gnt_b) begin
            wr2     <= 1'b1;
            wrdata2 <= b_data;
          end
        end
        STROBE: begin
          if (hold_done) begin
            wr1 <= 1'b0;
            wr2 <= 1'b0;
          end
        end
        default: begin
          wr1 <= 1'b0;
          wr2 <= 1'b0;
        end
      endcase
    end
  end

  // Client handshake: ack/err pulse for one cycle in DONE, busy outside IDLE.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      a_ack <= 1'b0;
      a_err <= 1'b0;
      b_ack <= 1'b0;
      b_err <= 1'b0;
      busy  <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      a_err <= 1'b0;
      b_ack <= 1'b0;
      b_err <= 1'b0;
      busy  <= (state_n != IDLE);
      if (state == VERIFY && (match || tmo_done)) begin
        if (sel_b) begin
          b_ack <= 1'b1;
          b_err <= ~match;
        end else begin
          a_ack <= 1'b1;
          a_err <= ~match;
        end
      end
    end
  end

endmodule

// File: tb/tb_shared_counter_writer.sv
// Scoreboard bench for shared_counter_writer with a behavioural counter register.
// Latency: checks ack cycle, strobe length/data/port, gaps and reset values.
// Backpressure: clients hold req until ack, then drop it (or keep it for held tests).
module tb_shared_counter_writer;

  logic       clk = 1'b0;
  logic       nrst;
  logic       a_req, b_req;
  logic [8:0] a_data, b_data;
  logic       a_ack, a_err, b_ack, b_err;
  logic [8:0] wrdata1, wrdata2;
  logic       wr1, wr2, busy;
  logic [8:0] value = 9'h000;
  logic       frz = 1'b0;
  logic       w1_q = 1'b0, w2_q = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  typedef struct { bit is_b; bit err; int cyc; } ack_exp_t;
  typedef struct { bit port2; logic [8:0] data; int len; } stb_exp_t;
  typedef struct { string name; int sel; logic [31:0] exp; } spot_t;

  ack_exp_t ackq[$];
  stb_exp_t stbq[$];
  spot_t    spotq[$];

  shared_counter_writer #(.HOLD(2), .TIMEOUT(15)) dut (
    .clk(clk), .nrst(nrst),
    .a_req(a_req), .a_data(a_data), .a_ack(a_ack), .a_err(a_err),
    .b_req(b_req), .b_data(b_data), .b_ack(b_ack), .b_err(b_err),
    .wrdata1(wrdata1), .wr1(wr1), .wrdata2(wrdata2), .wr2(wr2),
    .value(value), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register model: commits the port data at the end of the cycle the strobe falls (RELEASE).
  always @(posedge clk) begin
    w1_q <= (wr1 === 1'b1);
    w2_q <= (wr2 === 1'b1);
    if (frz) value <= 9'h000;
    else if (w1_q && wr1 === 1'b0) value <= wrdata1;
    else if (w2_q && wr2 === 1'b0) value <= wrdata2;
  end

  function automatic logic [31:0] probe(int sel);
    case (sel)
      0: probe = 32'({wr1, wr2, wrdata1, wrdata2, a_ack, a_err, b_ack, b_err, busy});
      1: probe = 32'(busy);
      2: probe = 32'(value);
      3: probe = 32'(wr1);
      4: probe = 32'(a_ack);
      5: probe = 32'(b_ack);
      6: probe = 32'(ackq.size());
      default: probe = 32'(stbq.size());
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Single checker process: spot checks, ack scoreboard and strobe protocol monitor.
  bit       p1 = 1'b0, p2 = 1'b0, have_prev = 1'b0;
  bit       w1, w2;
  int       len = 0, low_run = 0;
  stb_exp_t cur;
  ack_exp_t e;
  spot_t    sp;

  always @(negedge clk) begin
    w1 = (wr1 === 1'b1);
    w2 = (wr2 === 1'b1);
    while (spotq.size() > 0) begin
      sp = spotq.pop_front();
      chk(sp.name, probe(sp.sel), sp.exp);
    end
    if (a_ack === 1'b1 || b_ack === 1'b1 || a_err === 1'b1 || b_err === 1'b1) begin
      if (ackq.size() == 0) begin
        chk("unexpected_ack", 32'({a_ack, a_err, b_ack, b_err}), 32'd0);
      end else begin
        e = ackq.pop_front();
        chk("ack_client", 32'({a_ack, b_ack}), e.is_b ? 32'd1 : 32'd2);
        chk("ack_err", 32'({a_err, b_err}), e.is_b ? 32'(e.err) : 32'({e.err, 1'b0}));
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (w1 && w2) chk("strobe_overlap", 32'({w1, w2}), 32'd0);
    if ((w1 && !p1) || (w2 && !p2)) begin
      if (have_prev) chk("strobe_gap_ge2", 32'(low_run >= 2), 32'd1);
      low_run = 0;
      len = 1;
      if (stbq.size() == 0) begin
        chk("unexpected_strobe", 32'({w1, w2}), 32'd0);
      end else begin
        cur = stbq.pop_front();
        chk("strobe_port2", 32'(w2), 32'(cur.port2));
        chk("strobe_data", 32'(w2 ? wrdata2 : wrdata1), 32'(cur.data));
      end
    end else if (w1 || w2) begin
      len++;
      chk("strobe_data_stable", 32'(w2 ? wrdata2 : wrdata1), 32'(cur.data));
    end else begin
      if (p1 || p2) begin
        chk("strobe_len", 32'(len), 32'(cur.len));
        have_prev = 1'b1;
      end
      low_run++;
    end
    p1 = w1;
    p2 = w2;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_ack(input bit is_b, input bit err, input int at);
    ack_exp_t x;
    x.is_b = is_b; x.err = err; x.cyc = at;
    ackq.push_back(x);
  endtask

  task automatic exp_stb(input bit port2, input logic [8:0] data, input int n);
    stb_exp_t x;
    x.port2 = port2; x.data = data; x.len = n;
    stbq.push_back(x);
  endtask

  task automatic spot(input string name, input int sel, input logic [31:0] exp);
    spot_t x;
    x.name = name; x.sel = sel; x.exp = exp;
    spotq.push_back(x);
  endtask

  // Wait (bounded) for the client's ack, drop the requests in drop mask {b,a}, check busy after.
  task automatic wait_ack(input bit is_b, input bit [1:0] drop, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((is_b ? b_ack : a_ack) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) spot("ack_timeout", is_b ? 5 : 4, 32'd1);
    if (drop[0]) a_req = 1'b0;
    if (drop[1]) b_req = 1'b0;
    tick();
    spot("busy_after_ack", 1, 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    // Reset with both requests pending: outputs all zero, then A wins first.
    nrst = 1'b0; a_req = 1'b1; b_req = 1'b1; a_data = 9'h011; b_data = 9'h022;
    tick(); tick();
    spot("reset_outputs", 0, 32'd0);
    n = cyc;
    exp_stb(1'b0, 9'h011, 2); exp_ack(1'b0, 1'b0, n + 5);
    exp_stb(1'b1, 9'h022, 2); exp_ack(1'b1, 1'b0, n + 11);
    nrst = 1'b1;
    wait_ack(1'b0, 2'b01, 40);
    wait_ack(1'b1, 2'b10, 40);
    spot("value_after_simul", 2, 32'h022);

    // Held requests: grant order A, B, A, B, acks 6 cycles apart.
    a_data = 9'h0C3; b_data = 9'h13C; a_req = 1'b1; b_req = 1'b1;
    n = cyc;
    exp_stb(1'b0, 9'h0C3, 2); exp_ack(1'b0, 1'b0, n + 5);
    exp_stb(1'b1, 9'h13C, 2); exp_ack(1'b1, 1'b0, n + 11);
    exp_stb(1'b0, 9'h0C3, 2); exp_ack(1'b0, 1'b0, n + 17);
    exp_stb(1'b1, 9'h13C, 2); exp_ack(1'b1, 1'b0, n + 23);
    wait_ack(1'b0, 2'b00, 40);
    wait_ack(1'b1, 2'b00, 40);
    wait_ack(1'b0, 2'b00, 40);
    wait_ack(1'b1, 2'b11, 40);

    // Single write from A.
    tick();
    a_data = 9'h05A; a_req = 1'b1;
    n = cyc;
    exp_stb(1'b0, 9'h05A, 2); exp_ack(1'b0, 1'b0, n + 5);
    spot("busy_idle", 1, 32'd0);
    tick();
    spot("busy_rise", 1, 32'd1);
    spot("wr1_rise", 3, 32'd1);
    wait_ack(1'b0, 2'b01, 40);
    spot("value_single", 2, 32'h05A);

    // Simultaneous after A was served last: B first, then A.
    a_data = 9'h0AB; b_data = 9'h154; a_req = 1'b1; b_req = 1'b1;
    n = cyc;
    exp_stb(1'b1, 9'h154, 2); exp_ack(1'b1, 1'b0, n + 5);
    exp_stb(1'b0, 9'h0AB, 2); exp_ack(1'b0, 1'b0, n + 11);
    wait_ack(1'b1, 2'b10, 40);
    wait_ack(1'b0, 2'b01, 40);
    spot("value_simul2", 2, 32'h0AB);

    // Timeout: register frozen at zero, B writes 1FF, ack+err 15 cycles after first compare.
    frz = 1'b1;
    tick();
    b_data = 9'h1FF; b_req = 1'b1;
    n = cyc;
    exp_stb(1'b1, 9'h1FF, 2); exp_ack(1'b1, 1'b1, n + 19);
    wait_ack(1'b1, 2'b10, 60);
    spot("value_frozen", 2, 32'h000);
    frz = 1'b0;

    // Reset in the first STROBE cycle: strobe drops, no ack, fresh request completes.
    a_data = 9'h077; a_req = 1'b1;
    exp_stb(1'b0, 9'h077, 1);
    tick();
    spot("wr1_in_strobe", 3, 32'd1);
    nrst = 1'b0; a_req = 1'b0;
    tick();
    spot("reset_mid_outputs", 0, 32'd0);
    nrst = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    a_data = 9'h0EE; a_req = 1'b1;
    n = cyc;
    exp_stb(1'b0, 9'h0EE, 2); exp_ack(1'b0, 1'b0, n + 5);
    wait_ack(1'b0, 2'b01, 40);
    spot("value_after_reset", 2, 32'h0EE);

    // Every expected ack and strobe must have been consumed.
    tick(); tick();
    spot("ack_queue_empty", 6, 32'd0);
    spot("strobe_queue_empty", 7, 32'd0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
